// File: rtl/insn_fetch_ctrl_if.sv
// Fetch-side bus: memory address/data, redirect request and the decode handshake.
// The master modport is the fetch controller; slave is the memory/decode environment.
interface insn_fetch_ctrl_if #(
   parameter int MEM_ADDR = 10,
   parameter int LEN_REG  = 32
);
   logic                fetch_en;
   logic [MEM_ADDR-1:0] mem_a;
   logic [LEN_REG-1:0]  mem_q;
   logic                redirect_valid;
   logic [MEM_ADDR-1:0] redirect_pc;
   logic                insn_valid;
   logic                insn_ready;
   logic [LEN_REG-1:0]  insn;
   logic [MEM_ADDR-1:0] insn_pc;

   modport master (
      input  fetch_en, mem_q, redirect_valid, redirect_pc, insn_ready,
      output mem_a, insn_valid, insn, insn_pc
   );

   modport slave (
      output fetch_en, mem_q, redirect_valid, redirect_pc, insn_ready,
      input  mem_a, insn_valid, insn, insn_pc
   );
endinterface

// File: rtl/insn_fetch_ctrl.sv
// Instruction fetch sequencer: drives a synchronous-read memory one word per cycle
// and hands instructions to decode through a 2-entry {insn, pc} buffer.
module insn_fetch_ctrl #(
   parameter int MEM_ADDR = 10,
   parameter int LEN_REG  = 32,
   parameter int RESET_PC = 0
) (
   input logic clk,
   input logic rst,
   insn_fetch_ctrl_if.master bus
);
   logic [MEM_ADDR-1:0] pc;
   logic                inflight;
   logic [MEM_ADDR-1:0] inflight_pc;
   logic [1:0]          count;
   logic [LEN_REG-1:0]  head_insn, tail_insn;
   logic [MEM_ADDR-1:0] head_pc, tail_pc;

   logic       pop;
   logic       issue;
   logic [2:0] occ;

   assign pop = (count != 2'd0) & bus.insn_ready;
   // Occupancy after this edge, excluding a new issue; pop only when count>=1, so no underflow.
   assign occ   = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
   assign issue = bus.fetch_en & ~bus.redirect_valid & (occ < 3'd2);

   assign bus.mem_a      = pc;
   assign bus.insn_valid = (count != 2'd0);
   assign bus.insn       = head_insn;
   assign bus.insn_pc    = head_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= MEM_ADDR'(RESET_PC);
         inflight    <= 1'b0;
         inflight_pc <= '0;
         count       <= 2'd0;
         head_insn   <= '0;
         head_pc     <= '0;
         tail_insn   <= '0;
         tail_pc     <= '0;
      end else if (bus.redirect_valid) begin
         pc       <= bus.redirect_pc;
         inflight <= 1'b0;
         count    <= 2'd0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc          <= pc + MEM_ADDR'(1);
            inflight_pc <= pc;
         end
         // Head is always entry 0; a pop shifts the tail forward.
         case ({inflight, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  head_insn <= bus.mem_q;
                  head_pc   <= inflight_pc;
               end else begin
                  tail_insn <= bus.mem_q;
                  tail_pc   <= inflight_pc;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               head_insn <= tail_insn;
               head_pc   <= tail_pc;
               count     <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head_insn <= bus.mem_q;
                  head_pc   <= inflight_pc;
               end else begin
                  head_insn <= tail_insn;
                  head_pc   <= tail_pc;
                  tail_insn <= bus.mem_q;
                  tail_pc   <= inflight_pc;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// Bench for insn_fetch_ctrl: directed scenarios plus random traffic, checked
// cycle by cycle against a queue-based reference of issued and buffered fetches.
module tb_insn_fetch_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   insn_fetch_ctrl_if #(.MEM_ADDR(10), .LEN_REG(32)) ifa ();
   insn_fetch_ctrl_if #(.MEM_ADDR(4),  .LEN_REG(32)) ifb ();

   insn_fetch_ctrl #(.MEM_ADDR(10), .LEN_REG(32), .RESET_PC(0))  dut_a (.clk(clk), .rst(rst), .bus(ifa));
   insn_fetch_ctrl #(.MEM_ADDR(4),  .LEN_REG(32), .RESET_PC(14)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   // Synchronous-read memories: word i holds 0x1000+i.
   always @(posedge clk) begin
      ifa.mem_q <= 32'h1000 + 32'(ifa.mem_a);
      ifb.mem_q <= 32'h1000 + 32'(ifb.mem_a);
   end

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: next pc, the address in flight, and the program-ordered buffer.
   logic [9:0] m_pc;
   bit         m_infl;
   logic [9:0] m_infl_pc;
   logic [9:0] m_q[$];
   bit         m_clean;
   logic [9:0] hold_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 10'd0; m_infl = 1'b0; m_infl_pc = 10'd0; m_q.delete(); m_clean = 1'b1;
   endtask

   task automatic cyc(input bit fe, input bit rdy, input bit rv, input logic [9:0] rpc, input bit r);
      bit pop, issue;
      ifa.fetch_en = fe; ifa.insn_ready = rdy; ifa.redirect_valid = rv; ifa.redirect_pc = rpc;
      rst = r;
      chk("valid", 32'(ifa.insn_valid), 32'(m_q.size() != 0));
      chk("mem_a", 32'(ifa.mem_a), 32'(m_pc));
      if (m_q.size() != 0) begin
         chk("insn_pc", 32'(ifa.insn_pc), 32'(m_q[0]));
         chk("insn", ifa.insn, 32'h1000 + 32'(m_q[0]));
      end else if (m_clean) begin
         chk("rst_insn", ifa.insn, 32'h0);
         chk("rst_insn_pc", 32'(ifa.insn_pc), 32'h0);
      end
      if (r) model_reset();
      else begin
         pop   = (m_q.size() != 0) && rdy;
         issue = fe && !rv && (int'(m_q.size()) + int'(m_infl) - int'(pop) < 2);
         if (rv) begin
            m_q.delete(); m_infl = 1'b0; m_pc = rpc;
         end else begin
            if (pop) void'(m_q.pop_front());
            if (m_infl) begin m_q.push_back(m_infl_pc); m_clean = 1'b0; end
            m_infl = issue;
            if (issue) begin m_infl_pc = m_pc; m_pc = m_pc + 10'd1; end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      ifa.fetch_en = 1'b1; ifa.insn_ready = 1'b1; ifa.redirect_valid = 1'b0; ifa.redirect_pc = '0;
      ifb.fetch_en = 1'b1; ifb.insn_ready = 1'b1; ifb.redirect_valid = 1'b0; ifb.redirect_pc = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();

      // Release and stream; the 4-bit instance wraps 14,15,0,1.
      for (int k = 0; k < 8; k++) begin
         if (k < 2) chk("t1_no_valid", 32'(ifa.insn_valid), 32'h0);
         else begin
            chk("t1_pc", 32'(ifa.insn_pc), 32'(k - 2));
            chk("t4_pc", 32'(ifb.insn_pc), 32'((14 + k - 2) % 16));
            chk("t4_insn", ifb.insn, 32'h1000 + 32'((14 + k - 2) % 16));
         end
         cyc(1, 1, 0, 10'h0, 0);
      end

      // Back-pressure: head must hold while decode stalls.
      hold_pc = ifa.insn_pc;
      for (int k = 0; k < 4; k++) begin
         chk("t2_hold", 32'(ifa.insn_pc), 32'(hold_pc));
         cyc(1, 0, 0, 10'h0, 0);
      end
      repeat (6) cyc(1, 1, 0, 10'h0, 0);

      // Redirect to 0x040 mid-stream.
      cyc(1, 1, 1, 10'h040, 0);
      for (int k = 1; k <= 5; k++) begin
         if (k <= 2) chk("t3_bubble", 32'(ifa.insn_valid), 32'h0);
         else begin
            chk("t3_pc", 32'(ifa.insn_pc), 32'h040 + 32'(k - 3));
            chk("t3_insn", ifa.insn, 32'h1040 + 32'(k - 3));
         end
         cyc(1, 1, 0, 10'h0, 0);
      end

      // fetch_en low for 3 cycles, then resume.
      repeat (3) cyc(0, 1, 0, 10'h0, 0);
      repeat (6) cyc(1, 1, 0, 10'h0, 0);

      // Fill the buffer, then reset mid-operation.
      repeat (4) cyc(1, 0, 0, 10'h0, 0);
      cyc(1, 0, 0, 10'h0, 1);
      for (int k = 0; k < 4; k++) begin
         if (k == 0) chk("t6_flushed", 32'(ifa.insn_valid), 32'h0);
         if (k == 2) chk("t6_first_pc", 32'(ifa.insn_pc), 32'h0);
         cyc(1, 1, 0, 10'h0, 0);
      end

      // Random traffic incl. redirects, stalls and occasional reset.
      for (int k = 0; k < 600; k++)
         cyc(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0,
             10'($urandom), ($urandom % 97) == 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
